// File: rtl/sram512x64_ctrl_pkg.sv
// Shared widths, FSM state encoding and byte-enable expansion for the
// sram512x64 controller and its response buffer.
package sram512x64_ctrl_pkg;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 64;
    localparam int BE_W      = 8;
    localparam int RSP_DEPTH = 2;
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W     = $clog2(RSP_DEPTH);

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SLEEP  = 2'd1,
        WAKE   = 2'd2
    } state_t;

    // Each byte-enable bit becomes eight identical bit-write-mask bits.
    function automatic logic [DATA_W-1:0] be_to_bw(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] bw;
        bw = '0;
        for (int i = 0; i < BE_W; i++) begin
            bw[8*i +: 8] = {8{be[i]}};
        end
        return bw;
    endfunction

endpackage

// File: rtl/sram512x64_rsp_fifo.sv
// Small circular response buffer holding read words the consumer has not
// yet taken; reports its occupancy so the controller can track credits.
module sram512x64_rsp_fifo
    import sram512x64_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RSP_DEPTH);

    logic [DATA_W-1:0] mem [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // A pop frees a slot in the same cycle, so a push into a full buffer
    // is still safe when it coincides with a pop.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/sram512x64_ctrl.sv
// Initiator-side controller for one sram512x64 macro: write/read request
// channels, buffered read responses and deep-sleep sequencing.
// Optional build macro SRAM512X64_CTRL_WR_FWD_EN: forward a same-cycle,
// same-address write into the read response.
module sram512x64_ctrl
    import sram512x64_ctrl_pkg::*;
#(
    parameter int WAKE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              sleep_req,
    output logic              asleep,
    output logic              cenA,
    output logic              cenB,
    output logic [ADDR_W-1:0] aA,
    output logic [ADDR_W-1:0] aB,
    output logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] bw,
    output logic              deepsleep,
    output logic              powergate,
    input  logic [DATA_W-1:0] q
);

    localparam int WCNT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);
    localparam logic [CNT_W:0]    CREDIT_MAX = (CNT_W + 1)'(RSP_DEPTH);

    state_t            state;
    logic [WCNT_W-1:0] wake_cnt;
    logic              ready_base;
    logic              wr_acc_p0;
    logic              rd_acc_p0;
    logic [CNT_W:0]    credits;
    logic              vld_p1;
    logic [DATA_W-1:0] q_p1;
    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;

    // Stage p0: request acceptance drives the macro pins combinationally.
    assign ready_base = (state == ACTIVE) && !reset && !sleep_req;
    assign credits    = {1'b0, fifo_cnt} + (CNT_W + 1)'(vld_p1);
    assign wr_ready   = ready_base;
    assign rd_ready   = ready_base && (credits < CREDIT_MAX);
    assign wr_acc_p0  = wr_valid && wr_ready;
    assign rd_acc_p0  = rd_valid && rd_ready;

    assign cenB      = !(wr_acc_p0 && (wr_be != '0));
    assign aB        = wr_addr;
    assign d         = wr_data;
    assign bw        = be_to_bw(wr_be);
    assign cenA      = !rd_acc_p0;
    assign aA        = rd_addr;
    assign powergate = 1'b0;

    // Stage p1: the macro presents q for the read accepted last cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_acc_p0;
        end
    end

`ifdef SRAM512X64_CTRL_WR_FWD_EN
    logic              fwd_vld_p1;
    logic [DATA_W-1:0] fwd_data_p1;
    logic [DATA_W-1:0] fwd_bw_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_vld_p1 <= 1'b0;
        end else begin
            fwd_vld_p1 <= wr_acc_p0 && rd_acc_p0 && (wr_addr == rd_addr);
        end
    end

    always_ff @(posedge clk) begin
        fwd_data_p1 <= wr_data;
        fwd_bw_p1   <= bw;
    end

    // The macro reads before it writes, so overlay the colliding write here.
    assign q_p1 = fwd_vld_p1 ? ((q & ~fwd_bw_p1) | (fwd_data_p1 & fwd_bw_p1)) : q;
`else
    assign q_p1 = q;
`endif

    assign fifo_empty = (fifo_cnt == '0);
    assign rsp_valid  = vld_p1 || !fifo_empty;
    assign rsp_data   = fifo_empty ? q_p1 : fifo_head;
    assign fifo_pop   = !fifo_empty && rsp_ready;
    // q is only valid for one cycle; park it unless it leaves via bypass now.
    assign fifo_push  = vld_p1 && !(fifo_empty && rsp_ready);

    sram512x64_rsp_fifo u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (q_p1),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACTIVE;
            asleep    <= 1'b0;
            deepsleep <= 1'b0;
            wake_cnt  <= '0;
        end else begin
            case (state)
                ACTIVE: begin
                    if (sleep_req && !vld_p1 && fifo_empty) begin
                        state     <= SLEEP;
                        asleep    <= 1'b1;
                        deepsleep <= 1'b1;
                    end
                end
                SLEEP: begin
                    if (!sleep_req) begin
                        state     <= WAKE;
                        asleep    <= 1'b0;
                        deepsleep <= 1'b0;
                        wake_cnt  <= '0;
                    end
                end
                WAKE: begin
                    if (wake_cnt == WAKE_LAST) begin
                        state    <= ACTIVE;
                        wake_cnt <= '0;
                    end else begin
                        wake_cnt <= wake_cnt + WCNT_W'(1);
                    end
                end
                default: begin
                    state     <= ACTIVE;
                    asleep    <= 1'b0;
                    deepsleep <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram512x64_ctrl.sv
// Directed bench for sram512x64_ctrl with a behavioural read-before-write
// sram512x64 model attached to the macro pins.
module tb_sram512x64_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid, wr_ready;
    logic [8:0]  wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_be;
    logic        rd_valid, rd_ready;
    logic [8:0]  rd_addr;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_data;
    logic        sleep_req, asleep;
    logic        cenA, cenB;
    logic [8:0]  aA, aB;
    logic [63:0] d, bw, q;
    logic        deepsleep, powergate;

    int n_chk = 0;
    int n_fail = 0;

    sram512x64_ctrl #(.WAKE_CYCLES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .sleep_req (sleep_req),
        .asleep    (asleep),
        .cenA      (cenA),
        .cenB      (cenB),
        .aA        (aA),
        .aB        (aB),
        .d         (d),
        .bw        (bw),
        .deepsleep (deepsleep),
        .powergate (powergate),
        .q         (q)
    );

    always #5 clk = ~clk;

    // Macro model: registered read of the old word, masked write.
    logic [63:0] mem [512];
    always @(posedge clk) begin
        if (!cenA) q <= mem[aA];
        if (!cenB) mem[aB] <= (mem[aB] & ~bw) | (d & bw);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic [8:0] a, input logic [63:0] dat,
                      input logic [7:0] be, input logic [63:0] exp_bw);
        wr_valid = 1'b1; wr_addr = a; wr_data = dat; wr_be = be;
        @(negedge clk);
        chk({tag, "_rdy"}, wr_ready, 1);
        chk({tag, "_cenB"}, cenB, (be == 8'h00) ? 1 : 0);
        if (be != 8'h00) begin
            chk({tag, "_aB"}, aB, a);
            chk({tag, "_bw"}, bw, exp_bw);
        end
        step();
        wr_valid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [8:0] a, input logic [63:0] exp);
        rd_valid = 1'b1; rd_addr = a;
        @(negedge clk);
        chk({tag, "_cenA"}, cenA, 0);
        chk({tag, "_aA"}, aA, a);
        step();
        rd_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_vld"}, rsp_valid, 1);
        chk({tag, "_data"}, rsp_data, exp);
        step();
    endtask

    logic [63:0] rx [4];
    logic [63:0] exp_same;
    int acc, got, n;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1; sleep_req = 1'b0;
        wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cenA", cenA, 1);
        chk("rst_cenB", cenB, 1);
        chk("rst_asleep", asleep, 0);
        chk("rst_deepsleep", deepsleep, 0);
        chk("rst_powergate", powergate, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_ready", rd_ready, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_wr_ready", wr_ready, 1);
        chk("post_rst_rd_ready", rd_ready, 1);
        step();

        // Full write then read on the very next cycle.
        wr("w5", 9'd5, 64'hDEADBEEF_01234567, 8'hFF, 64'hFFFFFFFF_FFFFFFFF);
        rd_chk("r5", 9'd5, 64'hDEADBEEF_01234567);

        // Partial write, then a zero-enable write that must not touch the macro.
        wr("w5_lo", 9'd5, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, 64'h00000000_FFFFFFFF);
        rd_chk("r5_lo", 9'd5, 64'hDEADBEEF_FFFFFFFF);
        wr("w5_be0", 9'd5, 64'h0, 8'h00, 64'h0);
        rd_chk("r5_be0", 9'd5, 64'hDEADBEEF_FFFFFFFF);

        // Back-pressure: two credits, then in-order drain.
        for (int i = 0; i < 4; i++) begin
            wr("wfill", 9'(i), 64'h1000 + 64'(i), 8'hFF, 64'hFFFFFFFF_FFFFFFFF);
        end
        acc = 0; got = 0;
        rd_valid = 1'b1; rd_addr = 9'd0; rsp_ready = 1'b0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            if (c == 6) rsp_ready = 1'b1;
            @(negedge clk);
            if (c == 4) begin
                chk("bp_hold_vld", rsp_valid, 1);
                chk("bp_hold_data", rsp_data, 64'h1000);
                chk("bp_rd_ready", rd_ready, 0);
            end
            if (c == 5) chk("bp_accepts", 64'(acc), 2);
            if (rsp_valid && rsp_ready) begin
                rx[got] = rsp_data;
                got++;
            end
            if (rd_valid && rd_ready) acc++;
            step();
            if (acc == 4) rd_valid = 1'b0;
            else rd_addr = 9'(acc);
        end
        rd_valid = 1'b0;
        chk("bp_count", 64'(got), 4);
        chk("bp_rx0", rx[0], 64'h1000);
        chk("bp_rx1", rx[1], 64'h1001);
        chk("bp_rx2", rx[2], 64'h1002);
        chk("bp_rx3", rx[3], 64'h1003);
        step();

        // Same-cycle write and read to one address.
        wr("w9_old", 9'd9, 64'h2222, 8'hFF, 64'hFFFFFFFF_FFFFFFFF);
`ifdef SRAM512X64_CTRL_WR_FWD_EN
        exp_same = 64'h1111;
`else
        exp_same = 64'h2222;
`endif
        wr_valid = 1'b1; wr_addr = 9'd9; wr_data = 64'h1111; wr_be = 8'hFF;
        rd_valid = 1'b1; rd_addr = 9'd9;
        @(negedge clk);
        chk("same_cenA", cenA, 0);
        chk("same_cenB", cenB, 0);
        step();
        wr_valid = 1'b0; rd_valid = 1'b0;
        @(negedge clk);
        chk("same_vld", rsp_valid, 1);
        chk("same_data", rsp_data, exp_same);
        step();
        rd_chk("r9_new", 9'd9, 64'h1111);

        // Sleep request with one response outstanding.
        rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 9'd5;
        step();
        rd_valid = 1'b0; sleep_req = 1'b1; wr_valid = 1'b1; wr_addr = 9'd7; wr_be = 8'hFF;
        @(negedge clk);
        chk("slp_wr_blocked", wr_ready, 0);
        chk("slp_cenB", cenB, 1);
        chk("slp_pend_vld", rsp_valid, 1);
        step();
        wr_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("slp_wait_asleep", asleep, 0);
        chk("slp_wait_data", rsp_data, 64'hDEADBEEF_FFFFFFFF);
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("slp_drain_vld", rsp_valid, 1);
        step();
        n = 0;
        while (!asleep && n < 10) begin
            step();
            n++;
        end
        chk("slp_asleep", asleep, 1);
        chk("slp_deepsleep", deepsleep, 1);
        chk("slp_rsp_valid", rsp_valid, 0);
        chk("slp_rd_ready", rd_ready, 0);
        chk("slp_cenA", cenA, 1);

        // Wake: readies return two cycles after WAKE is entered.
        sleep_req = 1'b0;
        @(negedge clk);
        chk("wake_s_rd_ready", rd_ready, 0);
        step();
        @(negedge clk);
        chk("wake0_deepsleep", deepsleep, 0);
        chk("wake0_asleep", asleep, 0);
        chk("wake0_rd_ready", rd_ready, 0);
        step();
        @(negedge clk);
        chk("wake1_rd_ready", rd_ready, 0);
        step();
        @(negedge clk);
        chk("wake2_rd_ready", rd_ready, 1);
        chk("wake2_wr_ready", wr_ready, 1);
        step();

        // Reset while asleep.
        sleep_req = 1'b1;
        n = 0;
        while (!asleep && n < 10) begin
            step();
            n++;
        end
        chk("rs_asleep", asleep, 1);
        reset = 1'b1; sleep_req = 1'b0;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rs_deepsleep", deepsleep, 0);
        chk("rs_asleep_clr", asleep, 0);
        chk("rs_rsp_valid", rsp_valid, 0);
        chk("rs_cenA", cenA, 1);
        chk("rs_cenB", cenB, 1);
        chk("rs_active_rd_ready", rd_ready, 1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram512x64_ctrl.md
# sram512x64_ctrl

Initiator-side controller that owns one `sram512x64` macro in the eFPGA math-unit memory path. Converts independent valid/ready write and read request channels into the macro's active-low chip enables, 9-bit addresses and per-byte 64-bit write mask. Returns read data on a valid/ready response channel with a 2-entry credit-tracked buffer, and sequences the macro's deep-sleep pin.

## Interface
- `WAKE_CYCLES`, 2, cycles held in WAKE after `sleep_req` drops before requests are accepted again.
- `clk` in 1: single clock; drives `clkA` and `clkB` of the macro.
- `reset` in 1: synchronous, active-high.
- `wr_valid`/`wr_ready` in/out 1: write request handshake.
- `wr_addr` in 9, `wr_data` in 64, `wr_be` in 8: write address, data, byte enables (bit i covers bits 8i+7:8i).
- `rd_valid`/`rd_ready` in/out 1, `rd_addr` in 9: read request.
- `rsp_valid`/`rsp_ready` out/in 1, `rsp_data` out 64: read response.
- `sleep_req` in 1: level request to enter deep sleep.
- `asleep` out 1: high in SLEEP.
- `cenA`, `cenB` out 1: macro enables, active-low. `aA`, `aB` out 9. `d` out 64. `bw` out 64. `deepsleep`, `powergate` out 1. `q` in 64.

## Operation
- FSM states: ACTIVE, SLEEP, WAKE. Reset enters ACTIVE.
- ACTIVE:
  - `wr_ready = !sleep_req`.
  - `rd_ready = !sleep_req && credits < 2`, where credits = in-flight reads + buffered responses.
- Write accepted:
  - `cenB=0`, `aB=wr_addr`, `d=wr_data`, all combinational in the acceptance cycle.
  - `bw[8i+7:8i] = {8{wr_be[i]}}`.
  - If `wr_be==0`, the write is accepted but `cenB` stays 1.
- Read accepted: `cenA=0`, `aA=rd_addr` in the same cycle; the macro registers `q` at the next edge.
- Response path:
  - `rsp_data` is `q` (bypass) when the buffer is empty, otherwise the buffer head.
  - If the bypassed `q` is not taken (`rsp_ready=0`), `q` is pushed into the buffer.
  - Buffer depth is 2. The credit rule makes overflow impossible.
- Idle port enables are 1. `aA`/`aB`/`d`/`bw` are don't-care while the matching enable is 1.
- ACTIVE→SLEEP when `sleep_req=1`, no read is in flight, and the buffer is empty. Pending responses drain first.
- SLEEP: `deepsleep=1`, `asleep=1`, both readies 0, `cenA=cenB=1`. SLEEP→WAKE when `sleep_req=0`.
- WAKE: `deepsleep=0`, readies 0. After `WAKE_CYCLES` cycles (counter), WAKE→ACTIVE.
- `powergate` is tied 0.
- Same-cycle write and read to the same address: the macro is read-before-write, so the read returns the old word unless forwarding is enabled (see Configuration).

## Timing
- Read latency: request accepted at cycle N → `rsp_valid=1` at N+1 with the bypass path.
- Throughput: one read per cycle while `rsp_ready=1`.
- Write accepted at N is visible to a read accepted at N+1.
- `rsp_valid` and `rsp_data` stay stable while `rsp_valid && !rsp_ready`.
- Reset values:
  - `rsp_valid=0`, `asleep=0`, `deepsleep=0`, `powergate=0`, `cenA=cenB=1`.
  - In-flight flag, buffer and WAKE counter cleared.
  - `wr_ready`/`rd_ready` are 0 during the reset cycle and 1 in the first cycle after it (if `sleep_req=0`).
- Reset mid-SLEEP or mid-WAKE → ACTIVE on the next cycle, `deepsleep=0`. Buffered responses are discarded.
- `sleep_req` rising in the same cycle as a request: no acceptance in that cycle.

## Configuration
- `SRAM512X64_CTRL_WR_FWD_EN` defined: on a same-cycle write/read to the same address, the controller registers `wr_data`/`wr_be`. At N+1 it merges the enabled bytes over `q` before bypass or buffering, so the read returns the new data.
- `SRAM512X64_CTRL_WR_FWD_EN` undefined: no forwarding logic; the read returns the old data.

## Structure
- `sram512x64_ctrl_pkg`: `ADDR_W=9`, `DATA_W=64`, `BE_W=8`, `RSP_DEPTH=2`, FSM state enum, `be_to_bw` expansion function.
- Sub-module `sram512x64_rsp_fifo`: 2-entry response buffer with push/pop/count.

## Test plan
- Write 0xDEADBEEF_01234567 to addr 5 with `wr_be=0xFF`, then read addr 5 → `rsp_valid` one cycle after acceptance, data 0xDEADBEEF_01234567.
- Write `wr_be=0x0F` with 0xFFFFFFFF_FFFFFFFF over addr 5 → `bw=0x00000000_FFFFFFFF`; read → 0xDEADBEEF_FFFFFFFF. A write with `wr_be=0` → `cenB` stays 1 and contents are unchanged.
- Back-to-back reads of addr 0..3 with `rsp_ready=0` → `rd_ready` drops after 2 accepts. Release `rsp_ready` → responses for addr 0,1,2,3 in order, none lost.
- Same-cycle write 0x1111 and read at addr 9 (old value 0x2222) → 0x2222 without the macro, 0x1111 with `SRAM512X64_CTRL_WR_FWD_EN`.
- Assert `sleep_req` with one response pending → enters SLEEP only after that response is taken; `deepsleep=1`. Drop `sleep_req` → `rd_ready` returns exactly 2 cycles after WAKE is entered.
- Assert `reset` during SLEEP → the next cycle shows `deepsleep=0`, `rsp_valid=0`, `cenA=cenB=1`, state ACTIVE.
